fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 16-bit 5-stage datapath.
- Owns the PC, drives the instruction-memory address and latches the fetched instruction into IF/ID.
- Consumes BranchingSoFlush and the resolved target from the branch-equate stage: redirects the PC and squashes the wrong-path instruction in IF/ID.
- Honours the hazard unit's stall and detects HALT.

---
 rtl/fetch_stage.sv | 198 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit 5-stage datapath.
// Owns the PC, redirects on taken branches, honours hazard stalls and stops on HALT.
// Optional feature: define FETCH_PERF_COUNT_EN to add the FlushCount/StallCount outputs.
module fetch_stage #(
    parameter int unsigned          DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned          PC_INCREMENT = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 16'h0000,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR   = 16'hFFFF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  BranchingSoFlush,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Stall,
    input  logic [DATA_WIDTH-1:0] InstrData,
    output logic [DATA_WIDTH-1:0] InstrAddr,
    output logic [DATA_WIDTH-1:0] IF_ID_Instr,
    output logic [DATA_WIDTH-1:0] IF_ID_PCPlus2,
    output logic                  IF_ID_Valid,
    output logic                  Halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0]           FlushCount,
    output logic [15:0]           StallCount
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   pcp2_q, pcp2_d;
    logic                    valid_q, valid_d;
    logic                    halted_q, halted_d;
    logic [DATA_WIDTH-1:0]   pc_plus;
    logic                    halt_word;

    // Sequential successor of the PC (wraps modulo 2^DATA_WIDTH) and HALT opcode detect
    always_comb begin
        pc_plus   = pc_q + DATA_WIDTH'(PC_INCREMENT);
        halt_word = (InstrData == HALT_INSTR);
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a flush always beats a HALT word or a stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!BranchingSoFlush && !Stall && halt_word) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (BranchingSoFlush) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // PC and IF/ID next values, priority flush > stall > halt > sequential fetch
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcp2_d   = pcp2_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            ST_BOOT: begin
                instr_d = NOP_INSTR;
                pcp2_d  = '0;
                valid_d = 1'b0;
            end
            ST_RUN: begin
                if (BranchingSoFlush) begin
                    pc_d    = BranchTarget;
                    instr_d = NOP_INSTR;
                    pcp2_d  = '0;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (halt_word) begin
                    instr_d  = HALT_INSTR;
                    pcp2_d   = pc_plus;
                    valid_d  = 1'b1;
                    halted_d = 1'b1;
                end else begin
                    instr_d = InstrData;
                    pcp2_d  = pc_plus;
                    valid_d = 1'b1;
                    pc_d    = pc_plus;
                end
            end
            ST_HALT: begin
                if (BranchingSoFlush) begin
                    pc_d     = BranchTarget;
                    instr_d  = NOP_INSTR;
                    pcp2_d   = '0;
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                end else if (!Stall) begin
                    // HALT word already issued once; keep feeding bubbles
                    instr_d = NOP_INSTR;
                    pcp2_d  = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                pc_d     = RESET_VECTOR;
                instr_d  = NOP_INSTR;
                pcp2_d   = '0;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    // PC and IF/ID pipeline register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q     <= RESET_VECTOR;
            instr_q  <= NOP_INSTR;
            pcp2_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp2_q   <= pcp2_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Output mapping; InstrAddr is the live PC
    always_comb begin
        InstrAddr     = pc_q;
        IF_ID_Instr   = instr_q;
        IF_ID_PCPlus2 = pcp2_q;
        IF_ID_Valid   = valid_q;
        Halted        = halted_q;
    end

`ifdef FETCH_PERF_COUNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters: accepted flushes (RUN/HALT) and stall-held RUN cycles
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (BranchingSoFlush && (state_q != ST_BOOT) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if ((state_q == ST_RUN) && Stall && !BranchingSoFlush
            && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Counter outputs
    always_comb begin
        FlushCount = flush_cnt_q;
        StallCount = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural reference model compared every cycle,
// plus directed literal expectations from the test plan.
module tb_fetch_stage;

    logic        Clk;
    logic        Reset_n;
    logic        BranchingSoFlush;
    logic [15:0] BranchTarget;
    logic        Stall;
    logic [15:0] InstrData;
    logic [15:0] InstrAddr;
    logic [15:0] IF_ID_Instr;
    logic [15:0] IF_ID_PCPlus2;
    logic        IF_ID_Valid;
    logic        Halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] FlushCount;
    logic [15:0] StallCount;
`endif

    // Instruction memory stimulus controls
    logic        ovr_en;
    logic [15:0] ovr_val;
    logic        halt_en;
    logic [15:0] halt_at;

    int n_tests;
    int n_fail;

    fetch_stage dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .BranchingSoFlush (BranchingSoFlush),
        .BranchTarget     (BranchTarget),
        .Stall            (Stall),
        .InstrData        (InstrData),
        .InstrAddr        (InstrAddr),
        .IF_ID_Instr      (IF_ID_Instr),
        .IF_ID_PCPlus2    (IF_ID_PCPlus2),
        .IF_ID_Valid      (IF_ID_Valid),
        .Halted           (Halted)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .FlushCount       (FlushCount),
        .StallCount       (StallCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory contents: an override word, an optional HALT location, else 0xA000|addr[11:0]
    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic oe,
                                             input logic [15:0] ov, input logic he,
                                             input logic [15:0] ha);
        if (oe) return ov;
        if (he && a == ha) return 16'hFFFF;
        return 16'hA000 | {4'h0, a[11:0]};
    endfunction

    assign InstrData = mem_word(InstrAddr, ovr_en, ovr_val, halt_en, halt_at);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reference model: architectural view of PC, IF/ID and halt status
    logic [15:0] m_pc, m_instr, m_pcp2, m_word;
    logic        m_valid, m_halted, m_booting;
    logic [15:0] m_flush_n, m_stall_n;

    assign m_word = mem_word(m_pc, ovr_en, ovr_val, halt_en, halt_at);

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc      <= 16'h0000;
            m_instr   <= 16'h0000;
            m_pcp2    <= 16'h0000;
            m_valid   <= 1'b0;
            m_halted  <= 1'b0;
            m_booting <= 1'b1;
            m_flush_n <= 16'h0000;
            m_stall_n <= 16'h0000;
        end else if (m_booting) begin
            m_booting <= 1'b0;
        end else if (BranchingSoFlush) begin
            m_pc      <= BranchTarget;
            m_instr   <= 16'h0000;
            m_pcp2    <= 16'h0000;
            m_valid   <= 1'b0;
            m_halted  <= 1'b0;
            m_flush_n <= sat_inc(m_flush_n);
        end else if (m_halted) begin
            if (!Stall) begin
                m_instr <= 16'h0000;
                m_pcp2  <= 16'h0000;
                m_valid <= 1'b0;
            end
        end else if (Stall) begin
            m_stall_n <= sat_inc(m_stall_n);
        end else begin
            m_instr  <= m_word;
            m_pcp2   <= 16'(m_pc + 16'd2);
            m_valid  <= 1'b1;
            m_halted <= (m_word == 16'hFFFF);
            m_pc     <= (m_word == 16'hFFFF) ? m_pc : 16'(m_pc + 16'd2);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every visible output against the model
    task automatic compare_all();
        check("model.InstrAddr", InstrAddr, m_pc);
        check("model.IF_ID_Instr", IF_ID_Instr, m_instr);
        check("model.IF_ID_PCPlus2", IF_ID_PCPlus2, m_pcp2);
        check("model.IF_ID_Valid", 16'(IF_ID_Valid), 16'(m_valid));
        check("model.Halted", 16'(Halted), 16'(m_halted));
`ifdef FETCH_PERF_COUNT_EN
        check("model.FlushCount", FlushCount, m_flush_n);
        check("model.StallCount", StallCount, m_stall_n);
`endif
    endtask

    // Advance n clock edges, comparing against the model 1ns after each edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            compare_all();
        end
    endtask

    task automatic expect_if(input string name, input logic [15:0] addr, input logic [15:0] instr,
                             input logic [15:0] pcp2, input logic valid, input logic halted);
        check({name, ".addr"}, InstrAddr, addr);
        check({name, ".instr"}, IF_ID_Instr, instr);
        check({name, ".pcp2"}, IF_ID_PCPlus2, pcp2);
        check({name, ".valid"}, 16'(IF_ID_Valid), 16'(valid));
        check({name, ".halted"}, 16'(Halted), 16'(halted));
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        Reset_n          = 1'b1;
        BranchingSoFlush = 1'b0;
        BranchTarget     = 16'h0000;
        Stall            = 1'b0;
        ovr_en           = 1'b1;
        ovr_val          = 16'h1234;
        halt_en          = 1'b0;
        halt_at          = 16'h0000;
        #1 Reset_n = 1'b0;
        #1;
        expect_if("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #10 Reset_n = 1'b1;

        // 1: BOOT cycle then first fetch
        tick(1);
        expect_if("boot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick(1);
        expect_if("first_fetch", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);
        ovr_en = 1'b0;

        // 2: flush at PC=0006 to 0040
        tick(2);
        expect_if("seq_to_6", 16'h0006, 16'hA004, 16'h0006, 1'b1, 1'b0);
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h0040;
        tick(1);
        expect_if("flush_40", 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0);
        BranchingSoFlush = 1'b0;
        tick(1);
        expect_if("after_flush", 16'h0042, 16'hA040, 16'h0042, 1'b1, 1'b0);

        // 3: stall for 3 cycles at PC=0010, then stall+flush
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h000E;
        tick(1);
        BranchingSoFlush = 1'b0;
        tick(1);
        expect_if("pre_stall", 16'h0010, 16'hA00E, 16'h0010, 1'b1, 1'b0);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            expect_if("stall_hold", 16'h0010, 16'hA00E, 16'h0010, 1'b1, 1'b0);
        end
        Stall = 1'b0;
        tick(1);
        expect_if("stall_resume", 16'h0012, 16'hA010, 16'h0012, 1'b1, 1'b0);
        Stall            = 1'b1;
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h0080;
        tick(1);
        expect_if("stall_flush", 16'h0080, 16'h0000, 16'h0000, 1'b0, 1'b0);
        Stall            = 1'b0;
        BranchingSoFlush = 1'b0;

        // 4: HALT at 0020, stall in HALT, bubble, then wrong-path recovery
        halt_en          = 1'b1;
        halt_at          = 16'h0020;
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h0020;
        tick(1);
        BranchingSoFlush = 1'b0;
        tick(1);
        expect_if("halt_issue", 16'h0020, 16'hFFFF, 16'h0022, 1'b1, 1'b1);
        Stall = 1'b1;
        tick(1);
        expect_if("halt_stall", 16'h0020, 16'hFFFF, 16'h0022, 1'b1, 1'b1);
        Stall = 1'b0;
        tick(1);
        expect_if("halt_bubble", 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick(2);
        expect_if("halt_stay", 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b1);
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h0030;
        tick(1);
        expect_if("halt_flush", 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0);
        BranchingSoFlush = 1'b0;
        tick(1);
        expect_if("halt_recover", 16'h0032, 16'hA030, 16'h0032, 1'b1, 1'b0);

        // Flush arriving with the HALT word on InstrData: flush wins
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h001E;
        tick(1);
        BranchingSoFlush = 1'b0;
        tick(1);
        check("at_halt_word.addr", InstrAddr, 16'h0020);
        check("at_halt_word.data", InstrData, 16'hFFFF);
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h0050;
        tick(1);
        expect_if("flush_beats_halt", 16'h0050, 16'h0000, 16'h0000, 1'b0, 1'b0);
        BranchingSoFlush = 1'b0;
        halt_en          = 1'b0;

        // 5: PC wrap at FFFE
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'hFFFE;
        tick(1);
        BranchingSoFlush = 1'b0;
        tick(1);
        expect_if("wrap", 16'h0000, 16'hAFFE, 16'h0000, 1'b1, 1'b0);
        tick(2);
        expect_if("post_wrap", 16'h0004, 16'hA002, 16'h0004, 1'b1, 1'b0);

        // Asynchronous reset between clock edges
        #2 Reset_n = 1'b0;
        #1;
        expect_if("async_reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        compare_all();
        #3 Reset_n = 1'b1;
        // Flush during BOOT is ignored
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h0099;
        tick(1);
        expect_if("boot_ignores_flush", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        BranchingSoFlush = 1'b0;
        tick(1);
        expect_if("refetch", 16'h0002, 16'hA000, 16'h0002, 1'b1, 1'b0);

`ifdef FETCH_PERF_COUNT_EN
        // 6: performance counters and saturation
        check("cnt_after_reset.flush", FlushCount, 16'd0);
        check("cnt_after_reset.stall", StallCount, 16'd0);
        BranchingSoFlush = 1'b1;
        BranchTarget     = 16'h0100;
        tick(5);
        BranchingSoFlush = 1'b0;
        Stall            = 1'b1;
        tick(7);
        check("cnt.flush5", FlushCount, 16'd5);
        check("cnt.stall7", StallCount, 16'd7);
        tick(65530);
        check("cnt.stall_sat", StallCount, 16'hFFFF);
        check("cnt.flush_kept", FlushCount, 16'd5);
        Stall = 1'b0;
        tick(1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
